// File: rtl/hash_pkg.sv
// Shared configuration, table entry layout and the XOR-fold address hash
// for the hash lookup stage.
package hash_pkg;

  localparam int KEY_W = 32;
  localparam int VAL_W = 16;
  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);
  localparam int EW    = 1 + KEY_W + VAL_W;

  localparam int STAT_W = 32;

  // Upper bounds the generic fold works within.
  localparam int HASH_MAX_KEY_W = 256;
  localparam int HASH_MAX_AW    = 32;

  typedef struct packed {
    logic             vld;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] value;
  } entry_t;

  // Key bit b lands on address bit (b mod aw), which is the XOR of all aw-bit
  // slices taken LSB first, with the last slice zero-padded.
  function automatic logic [HASH_MAX_AW-1:0] fold_hash(
    input logic [HASH_MAX_KEY_W-1:0] key,
    input int                        key_w,
    input int                        aw
  );
    logic [HASH_MAX_AW-1:0] h;
    h = '0;
    for (int b = 0; b < HASH_MAX_KEY_W; b++) begin
      if (b < key_w) h[b % aw] ^= key[b];
    end
    return h;
  endfunction

endpackage

// File: rtl/hash_lookup_stage_if.sv
// Key-in, RAM read port and result-out signals of the hash lookup stage.
// slave = the stage itself, master = its environment.
interface hash_lookup_stage_if
  import hash_pkg::*;
#(
    parameter int KEY_W = hash_pkg::KEY_W,
    parameter int VAL_W = hash_pkg::VAL_W,
    parameter int AW    = hash_pkg::AW
);
    localparam int EW = 1 + KEY_W + VAL_W;

    logic [KEY_W-1:0] in_key;
    logic             in_valid;
    logic             in_ready;

    logic [AW-1:0]    ram_rd_addr;
    logic             ram_rd_en;
    logic [EW-1:0]    ram_rd_data;

    logic [KEY_W-1:0] out_key;
    logic             out_hit;
    logic [VAL_W-1:0] out_value;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_key, in_valid, ram_rd_data, out_ready,
        output in_ready, ram_rd_addr, ram_rd_en,
               out_key, out_hit, out_value, out_valid
    );

    modport master (
        output in_key, in_valid, ram_rd_data, out_ready,
        input  in_ready, ram_rd_addr, ram_rd_en,
               out_key, out_hit, out_value, out_valid
    );
endinterface

// File: rtl/hash_lookup_stage.sv
// Hashes keys to a table address, issues the RAM read, and compares the entry
// one cycle later. Optional hit/lookup counters under HASH_LOOKUP_STATS_EN.
module hash_lookup_stage
  import hash_pkg::*;
#(
    parameter int KEY_W = hash_pkg::KEY_W,
    parameter int VAL_W = hash_pkg::VAL_W,
    parameter int DEPTH = hash_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    hash_lookup_stage_if.slave       bus
`ifdef HASH_LOOKUP_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [STAT_W-1:0]        stat_lookups,
    output logic [STAT_W-1:0]        stat_hits
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + KEY_W + VAL_W;

    logic             s1_valid_q, s1_valid_d;
    logic [KEY_W-1:0] s1_key_q,   s1_key_d;
    logic             in_ready;
    logic             accept;

    logic             ent_vld;
    logic [KEY_W-1:0] ent_key;
    logic [VAL_W-1:0] ent_value;
    logic             hit;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        in_ready   = !s1_valid_q || bus.out_ready;
        accept     = bus.in_valid && in_ready;
        s1_valid_d = s1_valid_q;
        s1_key_d   = s1_key_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_key_d   = bus.in_key;
        end else if (bus.out_ready) begin
            s1_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_key_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_key_q   <= s1_key_d;
        end
    end

    // Withholding rd_en under stall keeps the RAM output register frozen.
    assign bus.in_ready    = in_ready;
    assign bus.ram_rd_en   = accept;
    assign bus.ram_rd_addr = AW'(fold_hash(HASH_MAX_KEY_W'(bus.in_key), KEY_W, AW));

    // NOTE: the table RAM is never reset; its stale output is harmless because
    // every use below is qualified by s1_valid_q.
    assign ent_vld   = bus.ram_rd_data[EW-1];
    assign ent_key   = bus.ram_rd_data[EW-2 -: KEY_W];
    assign ent_value = bus.ram_rd_data[VAL_W-1:0];
    assign hit       = s1_valid_q && ent_vld && (ent_key == s1_key_q);

    assign bus.out_valid = s1_valid_q;
    assign bus.out_key   = s1_valid_q ? s1_key_q : '0;
    assign bus.out_hit   = hit;
    assign bus.out_value = hit ? ent_value : '0;

`ifdef HASH_LOOKUP_STATS_EN
    logic [STAT_W-1:0] stat_lookups_q, stat_lookups_d;
    logic [STAT_W-1:0] stat_hits_q,    stat_hits_d;
    logic              out_fire;

    always_comb begin
        out_fire       = s1_valid_q && bus.out_ready;
        stat_lookups_d = stat_lookups_q;
        stat_hits_d    = stat_hits_q;
        if (stat_clr) begin
            stat_lookups_d = '0;
            stat_hits_d    = '0;
        end else if (out_fire) begin
            if (stat_lookups_q != '1) stat_lookups_d = stat_lookups_q + 1'b1;
            if (hit && stat_hits_q != '1) stat_hits_d = stat_hits_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups_q <= '0;
            stat_hits_q    <= '0;
        end else begin
            stat_lookups_q <= stat_lookups_d;
            stat_hits_q    <= stat_hits_d;
        end
    end

    assign stat_lookups = stat_lookups_q;
    assign stat_hits    = stat_hits_q;
`endif

endmodule

// File: tb/tb_hash_lookup_stage.sv
// Self-checking bench for hash_lookup_stage: behavioural read-first RAM,
// scoreboard of expected results, one task per scenario.
module tb_hash_lookup_stage;
    import hash_pkg::*;

    localparam int TKW = 32;
    localparam int TVW = 16;
    localparam int TDEPTH = 512;
    localparam int TAW = 9;
    localparam int TEW = 1 + TKW + TVW;

    typedef struct packed {
        logic [TKW-1:0] key;
        logic           hit;
        logic [TVW-1:0] value;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_lookup_stage_if #(.KEY_W(TKW), .VAL_W(TVW), .AW(TAW)) bus ();

`ifdef HASH_LOOKUP_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
`endif

    hash_lookup_stage #(.KEY_W(TKW), .VAL_W(TVW), .DEPTH(TDEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef HASH_LOOKUP_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_lookups (stat_lookups),
        .stat_hits    (stat_hits)
`endif
    );

    logic [TEW-1:0] mem [TDEPTH];
    always @(posedge clk) if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];

    int      n_checks = 0;
    int      n_pass   = 0;
    int      results_seen = 0;
    result_t sb_q [$];

    function automatic logic [TAW-1:0] tb_hash(input logic [TKW-1:0] k);
        return k[8:0] ^ k[17:9] ^ k[26:18] ^ {4'b0, k[31:27]};
    endfunction

    function automatic result_t model(input logic [TKW-1:0] k);
        entry_t  e;
        result_t r;
        e       = entry_t'(mem[tb_hash(k)]);
        r.key   = k;
        r.hit   = e.vld && (e.key == k);
        r.value = r.hit ? e.value : '0;
        return r;
    endfunction

    // Scoreboard: pop on each output handshake, push on each accepted key.
    always @(negedge clk) begin
        result_t exp_r;
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got key=%h with no result pending", bus.out_key);
            end else begin
                exp_r = sb_q.pop_front();
                results_seen++;
                if ({bus.out_key, bus.out_hit, bus.out_value} !== exp_r)
                    $display("FAIL sb_result: got key=%h hit=%b val=%h, want key=%h hit=%b val=%h",
                             bus.out_key, bus.out_hit, bus.out_value, exp_r.key, exp_r.hit, exp_r.value);
                else
                    n_pass++;
            end
        end
        if (!rst && bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.in_key));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_hit, bus.out_value, bus.out_key, bus.ram_rd_en, bus.in_ready}
            !== {1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1})
            $display("FAIL reset_outputs: got valid=%b hit=%b val=%h key=%h rd_en=%b in_ready=%b, want all 0 and in_ready=1",
                     bus.out_valid, bus.out_hit, bus.out_value, bus.out_key, bus.ram_rd_en, bus.in_ready);
        else n_pass++;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_hit();
        mem[5] = {1'b1, 32'h0000_0005, 16'hBEEF};
        bus.in_key = 32'h5; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.ram_rd_addr !== 9'd5 || bus.ram_rd_en !== 1'b1)
            $display("FAIL hit_issue: got addr=%0d rd_en=%b, want addr=5 rd_en=1", bus.ram_rd_addr, bus.ram_rd_en);
        else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_hit, bus.out_value} !== {1'b1, 1'b1, 16'hBEEF})
            $display("FAIL hit_result: got valid=%b hit=%b val=%h, want 1 1 beef",
                     bus.out_valid, bus.out_hit, bus.out_value);
        else n_pass++;
        tick();
    endtask

    task automatic test_miss();
        mem[4] = '0;
        bus.in_key = 32'h0000_0205; bus.in_valid = 1'b1;
        #1;
        n_checks++;
        if (bus.ram_rd_addr !== 9'd4)
            $display("FAIL miss_addr: got addr=%0d, want 4", bus.ram_rd_addr);
        else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_hit, bus.out_value} !== {1'b1, 1'b0, 16'h0})
            $display("FAIL miss_invalid: got valid=%b hit=%b val=%h, want 1 0 0000",
                     bus.out_valid, bus.out_hit, bus.out_value);
        else n_pass++;
        tick();
        mem[4] = {1'b1, 32'h0000_0004, 16'h1234};
        bus.in_key = 32'h0000_0205; bus.in_valid = 1'b1;
        tick();
        bus.in_key = 32'h0000_0004;
        #1;
        n_checks++;
        if ({bus.out_hit, bus.out_value} !== {1'b0, 16'h0})
            $display("FAIL miss_keymismatch: got hit=%b val=%h, want 0 0000", bus.out_hit, bus.out_value);
        else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [TKW-1:0] keys [8];
        int seen0;
        keys = '{32'h0000_0010, 32'h0000_0011, 32'h0001_0012, 32'h00A0_0013,
                 32'h0000_0030, 32'h1234_0031, 32'h0000_0040, 32'hF000_0041};
        for (int i = 0; i < 8; i += 2) mem[tb_hash(keys[i])] = {1'b1, keys[i], 16'hA000 + 16'(i)};
        seen0 = results_seen;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_key = keys[i]; bus.in_valid = 1'b1;
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1)
                $display("FAIL b2b_in_ready: key %0d got in_ready=%b, want 1", i, bus.in_ready);
            else n_pass++;
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (results_seen - seen0 !== 8)
            $display("FAIL b2b_count: got %0d results in 8 cycles, want 8", results_seen - seen0);
        else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        mem[7] = {1'b1, 32'h0000_0007, 16'h7777};
        bus.out_ready = 1'b1;
        bus.in_key = 32'h7; bus.in_valid = 1'b1;
        tick();
        bus.in_key = 32'h5; bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({bus.in_ready, bus.ram_rd_en, bus.out_valid, bus.out_key, bus.out_hit, bus.out_value}
                !== {1'b0, 1'b0, 1'b1, 32'h7, 1'b1, 16'h7777})
                $display("FAIL stall_hold: cycle %0d got in_ready=%b rd_en=%b valid=%b key=%h hit=%b val=%h, want 0 0 1 00000007 1 7777",
                         c, bus.in_ready, bus.ram_rd_en, bus.out_valid, bus.out_key, bus.out_hit, bus.out_value);
            else n_pass++;
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.ram_rd_en !== 1'b1)
            $display("FAIL stall_release: got in_ready=%b rd_en=%b, want 1 1", bus.in_ready, bus.ram_rd_en);
        else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_key, bus.out_value} !== {32'h5, 16'hBEEF})
            $display("FAIL stall_next: got key=%h val=%h, want 00000005 beef", bus.out_key, bus.out_value);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_key = 32'h5; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1)
            $display("FAIL rstmid_pending: got out_valid=%b, want 1", bus.out_valid);
        else n_pass++;
        rst = 1'b1;
        #1;
        sb_q.delete();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL rstmid_async: got out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        else n_pass++;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
                $display("FAIL rstmid_stale: cycle %0d got out_valid=%b in_ready=%b, want 0 1",
                         c, bus.out_valid, bus.in_ready);
            else n_pass++;
            tick();
        end
    endtask

`ifdef HASH_LOOKUP_STATS_EN
    task automatic test_stats();
        logic [TKW-1:0] keys [6];
        keys = '{32'h5, 32'h7, 32'h0000_0205, 32'h4, 32'h5, 32'h0000_0205};
        bus.out_ready = 1'b1;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_checks++;
        if (stat_lookups !== 32'd0 || stat_hits !== 32'd0)
            $display("FAIL stats_clr: got lookups=%0d hits=%0d, want 0 0", stat_lookups, stat_hits);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            bus.in_key = keys[i]; bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        n_checks++;
        if (stat_lookups !== 32'd6 || stat_hits !== 32'd4)
            $display("FAIL stats_count: got lookups=%0d hits=%0d, want 6 4", stat_lookups, stat_hits);
        else n_pass++;
        bus.in_key = 32'h5; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_checks++;
        if (stat_lookups !== 32'd0 || stat_hits !== 32'd0)
            $display("FAIL stats_clr_prio: got lookups=%0d hits=%0d, want 0 0", stat_lookups, stat_hits);
        else n_pass++;
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < TDEPTH; i++) mem[i] = '0;
        bus.ram_rd_data = '0;
        bus.in_key = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_hit();
        test_miss();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef HASH_LOOKUP_STATS_EN
        test_stats();
`endif
        n_checks++;
        if (sb_q.size() !== 0)
            $display("FAIL sb_drain: got %0d results never emitted, want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
